icnd2110_multi: RTL and testbench

//  Parametrised successor to the single-lane ICND2110 driver. Streams 16-bit pixel words from a shared

---
 rtl/icnd2110_pkg.sv | 22 ++
 rtl/icnd2110_bitclk.sv | 55 +++++
 rtl/icnd2110_multi.sv | 194 +++++++++++++++++++
 tb/tb_icnd2110_multi.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/icnd2110_pkg.sv
// rtl/icnd2110_pkg.sv - shared types and constants for the multi-lane ICND2110 driver
//
// Purpose: frame FSM state encoding, header magic byte, pixel word width and
//          the header word builder shared by the driver files.
// Ports:   none (package).
package icnd2110_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2,
    LATCH  = 2'd3
  } state_e;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  localparam int         WORD_W    = 16;

  function automatic logic [WORD_W-1:0] hdr_word(input logic up, input logic pwm_wider);
    return {HDR_MAGIC, 6'b0, up, pwm_wider};
  endfunction

endpackage

// File: rtl/icnd2110_bitclk.sv
// rtl/icnd2110_bitclk.sv - bit-clock divider for the shared LED string clock
//
// Purpose: while en_i is high, generates spi_c with CLK_DIV clocks low then
//          CLK_DIV clocks high per bit, and counts bits within a 16-bit word.
//          Held cleared (spi_c low, bit 0) while en_i is low.
// Ports:   clk, rst_n       system clock, asynchronous active-low reset
//          en_i             run the divider
//          spi_c_o          bit clock
//          set_bit_o        strobe: the next edge is a falling edge (next bit set)
//          last_bit_o       strobe: as set_bit_o, on the last bit of a word
module icnd2110_bitclk
  import icnd2110_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic spi_c_o,
  output logic set_bit_o,
  output logic last_bit_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(WORD_W);

  logic [DW-1:0] div_q;
  logic          phase_q;
  logic [BW-1:0] bit_q;
  logic          tick;

  assign tick       = en_i && (div_q == DW'(CLK_DIV - 1));
  assign set_bit_o  = tick && phase_q;
  assign last_bit_o = set_bit_o && (bit_q == BW'(WORD_W - 1));
  assign spi_c_o    = phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      phase_q <= 1'b0;
      bit_q   <= '0;
    end else if (!en_i) begin
      div_q   <= '0;
      phase_q <= 1'b0;
      bit_q   <= '0;
    end else if (tick) begin
      div_q   <= '0;
      phase_q <= ~phase_q;
      if (phase_q) bit_q <= bit_q + BW'(1);
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

endmodule

// File: rtl/icnd2110_multi.sv
// rtl/icnd2110_multi.sv - multi-lane ICND2110 LED string driver
//
// Purpose: streams 16-bit pixel words from a frame-buffer read port onto
//          CHANNELS lockstep clock/data LED strings: a header word, then
//          chipcount*WORDS_PER_CHIP data words, then a latch gap.
// Optional feature macro: TEST_PATTERN_EN (adds test_en; synthetic word data).
// Ports:   clk, rst_n       system clock, asynchronous active-low reset
//          chipcount        chips per lane, sampled at frame start
//          cfg_pwm_wider    header bit 0, sampled at frame start
//          cfg_up           header bit 1, sampled at frame start
//          run              free-run frames; 0 stops after the current frame
//          test_en          (TEST_PATTERN_EN only) pattern data, sampled at frame start
//          fb_addr, fb_rd   frame-buffer read address and strobe
//          fb_data          read data, valid one cycle after fb_rd
//          spi_c, spi_d     shared bit clock, per-lane data (MSB first)
//          start_flag       pulse on first HEADER cycle
//          busy             high outside IDLE
module icnd2110_multi
  import icnd2110_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int MAX_CHIPS      = 256,
  parameter int WORDS_PER_CHIP = 3,
  parameter int CLK_DIV        = 2,
  parameter int LATCH_CYCLES   = 64,
  parameter int ADDR_W         = 12
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [$clog2(MAX_CHIPS+1)-1:0]   chipcount,
  input  logic                             cfg_pwm_wider,
  input  logic                             cfg_up,
  input  logic                             run,
`ifdef TEST_PATTERN_EN
  input  logic                             test_en,
`endif
  output logic [ADDR_W-1:0]                fb_addr,
  output logic                             fb_rd,
  input  logic [WORD_W-1:0]                fb_data,
  output logic                             spi_c,
  output logic [CHANNELS-1:0]              spi_d,
  output logic                             start_flag,
  output logic                             busy
);

  localparam int WN_W = $clog2(MAX_CHIPS * WORDS_PER_CHIP + 1);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int LC_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  // The prefetch burst plus its one-cycle read latency must fit in one word.
  if (CHANNELS + 1 > 32 * CLK_DIV) begin : g_prefetch_fit
    $error("icnd2110_multi: CHANNELS+1 exceeds 32*CLK_DIV");
  end

  function automatic logic [ADDR_W-1:0] addr_of(input logic [WN_W-1:0] k);
    return ADDR_W'(32'(k) * 32'(CHANNELS));
  endfunction

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  shift_q  [CHANNELS];
  logic [WORD_W-1:0]  shadow_q [CHANNELS];
  logic [WN_W-1:0]    nxt_q;      // index of the next word to be loaded
  logic [WN_W-1:0]    total_q;
  logic               test_q;
  logic [LC_W-1:0]    lat_q;
  logic               fb_rd_q;
  logic [ADDR_W-1:0]  fb_addr_q;
  logic [CH_W-1:0]    rd_ch_q;
  logic               cap_q;
  logic [CH_W-1:0]    cap_ch_q;
  logic               start_q;

  logic set_bit, last_bit, lat_done, more, frame_go, load_word, pf_next;
  logic test_sel;
  logic shifting;

`ifdef TEST_PATTERN_EN
  assign test_sel = test_en;
`else
  assign test_sel = 1'b0;
`endif

  assign shifting = (state_q == HEADER) || (state_q == DATA);

  icnd2110_bitclk #(
    .CLK_DIV (CLK_DIV)
  ) u_bitclk (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (shifting),
    .spi_c_o    (spi_c),
    .set_bit_o  (set_bit),
    .last_bit_o (last_bit)
  );

  assign lat_done  = (state_q == LATCH) && (lat_q == LC_W'(LATCH_CYCLES - 1));
  assign more      = nxt_q < total_q;
  assign load_word = last_bit && more;
  assign pf_next   = load_word && ((nxt_q + WN_W'(1)) < total_q) && !test_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    frame_go = 1'b0;
    case (state_q)
      IDLE:    if (run) state_d = HEADER;
      HEADER:  if (last_bit) state_d = more ? DATA : LATCH;
      DATA:    if (last_bit && !more) state_d = LATCH;
      LATCH:   if (lat_done) state_d = run ? HEADER : IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == HEADER && state_q != HEADER) frame_go = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        shift_q[c]  <= '0;
        shadow_q[c] <= '0;
      end
      nxt_q     <= '0;
      total_q   <= '0;
      test_q    <= 1'b0;
      lat_q     <= '0;
      fb_rd_q   <= 1'b0;
      fb_addr_q <= '0;
      rd_ch_q   <= '0;
      cap_q     <= 1'b0;
      cap_ch_q  <= '0;
      start_q   <= 1'b0;
    end else begin
      start_q  <= frame_go;
      cap_q    <= fb_rd_q;
      cap_ch_q <= rd_ch_q;
      if (cap_q) shadow_q[cap_ch_q] <= fb_data;
      lat_q <= (state_q == LATCH) ? lat_q + LC_W'(1) : '0;

      // Read burst: one read per cycle for lanes 0..CHANNELS-1 at consecutive addresses.
      if (fb_rd_q && rd_ch_q != CH_W'(CHANNELS - 1)) begin
        rd_ch_q   <= rd_ch_q + CH_W'(1);
        fb_addr_q <= fb_addr_q + ADDR_W'(1);
      end else begin
        fb_rd_q <= 1'b0;
      end

      if (frame_go) begin
        test_q  <= test_sel;
        total_q <= WN_W'(32'(chipcount) * 32'(WORDS_PER_CHIP));
        nxt_q   <= '0;
        for (int c = 0; c < CHANNELS; c++) shift_q[c] <= hdr_word(cfg_up, cfg_pwm_wider);
        if (chipcount != '0 && !test_sel) begin
          fb_rd_q   <= 1'b1;
          fb_addr_q <= '0;
          rd_ch_q   <= '0;
        end
      end else if (load_word) begin
        // The last lane's read may land on this very edge, so forward it.
        for (int c = 0; c < CHANNELS; c++) begin
          if (test_q)
            shift_q[c] <= {8'(nxt_q), 4'(c), 4'h0};
          else if (cap_q && cap_ch_q == CH_W'(c))
            shift_q[c] <= fb_data;
          else
            shift_q[c] <= shadow_q[c];
        end
        nxt_q <= nxt_q + WN_W'(1);
        if (pf_next) begin
          fb_rd_q   <= 1'b1;
          fb_addr_q <= addr_of(nxt_q + WN_W'(1));
          rd_ch_q   <= '0;
        end
      end else if (last_bit) begin
        for (int c = 0; c < CHANNELS; c++) shift_q[c] <= '0;
      end else if (set_bit) begin
        for (int c = 0; c < CHANNELS; c++) shift_q[c] <= {shift_q[c][WORD_W-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    spi_d = '0;
    for (int c = 0; c < CHANNELS; c++) spi_d[c] = shift_q[c][WORD_W-1];
  end

  assign fb_rd      = fb_rd_q;
  assign fb_addr    = fb_addr_q;
  assign start_flag = start_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_icnd2110_multi.sv
// tb/tb_icnd2110_multi.sv - directed self-checking bench for icnd2110_multi
module tb_icnd2110_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  chipcount;
  logic        cfg_pwm_wider, cfg_up, run;
`ifdef TEST_PATTERN_EN
  logic        test_en;
`endif
  logic [11:0] fb_addr;
  logic        fb_rd;
  logic [15:0] fb_data = 16'h0;
  logic        spi_c;
  logic [3:0]  spi_d;
  logic        start_flag, busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  icnd2110_multi dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .chipcount     (chipcount),
    .cfg_pwm_wider (cfg_pwm_wider),
    .cfg_up        (cfg_up),
    .run           (run),
`ifdef TEST_PATTERN_EN
    .test_en       (test_en),
`endif
    .fb_addr       (fb_addr),
    .fb_rd         (fb_rd),
    .fb_data       (fb_data),
    .spi_c         (spi_c),
    .spi_d         (spi_d),
    .start_flag    (start_flag),
    .busy          (busy)
  );

  // Frame buffer: buffer[i] = 16'h1000 + i, one-cycle read latency.
  always @(posedge clk) begin
    if (fb_rd) fb_data <= 16'h1000 + 16'(fb_addr);
  end

  // Monitor: deserialise each lane on spi_c rising, count activity.
  logic        clr = 1'b0;
  logic        c_prev = 1'b0;
  logic [15:0] sh   [4];
  int          bitn [4];
  int          wn   [4];
  logic [15:0] wbuf [4][32];
  int          busy_cnt, start_cnt, rd_cnt, rise_n, cyc;
  int          rise_t [2];

  always @(negedge clk) begin
    cyc++;
    if (clr || !rst_n) begin
      for (int l = 0; l < 4; l++) begin
        bitn[l] = 0;
        wn[l]   = 0;
        sh[l]   = 16'h0;
      end
      busy_cnt  = 0;
      start_cnt = 0;
      rd_cnt    = 0;
      rise_n    = 0;
    end else begin
      if (busy)       busy_cnt++;
      if (start_flag) start_cnt++;
      if (fb_rd)      rd_cnt++;
      if (spi_c && !c_prev) begin
        if (rise_n < 2) rise_t[rise_n] = cyc;
        rise_n++;
        for (int l = 0; l < 4; l++) begin
          sh[l] = {sh[l][14:0], spi_d[l]};
          bitn[l]++;
          if (bitn[l] == 16) begin
            if (wn[l] < 32) wbuf[l][wn[l]] = sh[l];
            wn[l]++;
            bitn[l] = 0;
          end
        end
      end
    end
    c_prev = spi_c;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    @(posedge clk);
    @(posedge clk);
    clr = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (start_flag !== 1'b1 && k < budget);
    if (start_flag !== 1'b1) check({tag, "_start_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy !== 1'b0 && k < budget);
    if (busy !== 1'b0) check({tag, "_idle_timeout"}, 1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; chipcount = 9'd0; cfg_up = 1'b0; cfg_pwm_wider = 1'b0;
`ifdef TEST_PATTERN_EN
    test_en = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_spi_c", 32'(spi_c), 0);
    check("rst_spi_d", 32'(spi_d), 0);
    check("rst_fb_rd", 32'(fb_rd), 0);
    check("rst_fb_addr", 32'(fb_addr), 0);
    check("rst_start", 32'(start_flag), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame, chipcount=2; run dropped and inputs changed mid-DATA.
    clear_mon();
    chipcount = 9'd2; cfg_up = 1'b1; cfg_pwm_wider = 1'b0; run = 1'b1;
    wait_start("t1", 50);
    repeat (100) @(negedge clk);
    run = 1'b0; chipcount = 9'd5; cfg_up = 1'b0; cfg_pwm_wider = 1'b1;
    wait_idle("t1", 2000);
    check("t1_words_l2", wn[2], 7);
    for (int l = 0; l < 4; l++) check($sformatf("t1_hdr_l%0d", l), 32'(wbuf[l][0]), 32'h0000A502);
    for (int j = 0; j < 6; j++) check($sformatf("t1_l2_w%0d", j), 32'(wbuf[2][j+1]), 32'h1002 + 32'(4*j));
    check("t1_l0_w5", 32'(wbuf[0][6]), 32'h1014);
    check("t1_rd_cnt", rd_cnt, 24);
    check("t1_busy_cycles", busy_cnt, 512);
    check("t1_spi_c_period", rise_t[1] - rise_t[0], 4);
    repeat (100) @(negedge clk);
    check("t1_start_cnt", start_cnt, 1);
    check("t1_busy_after", 32'(busy), 0);

    // Free-running two frames back to back, chipcount=1.
    clear_mon();
    chipcount = 9'd1; cfg_up = 1'b1; cfg_pwm_wider = 1'b1; run = 1'b1;
    wait_start("t2a", 50);
    wait_start("t2b", 1000);
    run = 1'b0;
    wait_idle("t2", 2000);
    check("t2_start_cnt", start_cnt, 2);
    check("t2_busy_cycles", busy_cnt, 640);
    check("t2_rd_cnt", rd_cnt, 24);
    check("t2_words_l3", wn[3], 8);
    check("t2_hdr2_l3", 32'(wbuf[3][4]), 32'h0000A503);
    check("t2_f2_w0_l3", 32'(wbuf[3][5]), 32'h1003);
    check("t2_f2_w2_l3", 32'(wbuf[3][7]), 32'h100B);

    // chipcount=0: header then latch, no reads.
    clear_mon();
    chipcount = 9'd0; cfg_up = 1'b0; cfg_pwm_wider = 1'b1; run = 1'b1;
    wait_start("t3", 50);
    run = 1'b0;
    wait_idle("t3", 500);
    check("t3_words_l0", wn[0], 1);
    check("t3_hdr_l0", 32'(wbuf[0][0]), 32'h0000A501);
    check("t3_hdr_l3", 32'(wbuf[3][0]), 32'h0000A501);
    check("t3_rd_cnt", rd_cnt, 0);
    check("t3_busy_cycles", busy_cnt, 128);

    // Asynchronous reset mid-word, then a fresh frame.
    clear_mon();
    chipcount = 9'd2; cfg_up = 1'b0; cfg_pwm_wider = 1'b0; run = 1'b1;
    wait_start("t5", 50);
    repeat (150) @(negedge clk);
    check("t5_busy_before", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_spi_c", 32'(spi_c), 0);
    check("t5_rst_spi_d", 32'(spi_d), 0);
    check("t5_rst_fb_rd", 32'(fb_rd), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_start", 32'(start_flag), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_start("t5b", 50);
    run = 1'b0;
    wait_idle("t5", 2000);
    check("t5_words_l0", wn[0], 7);
    check("t5_hdr_l0", 32'(wbuf[0][0]), 32'h0000A500);
    check("t5_l0_w0", 32'(wbuf[0][1]), 32'h1000);
    check("t5_l0_w5", 32'(wbuf[0][6]), 32'h1014);

`ifdef TEST_PATTERN_EN
    clear_mon();
    chipcount = 9'd1; test_en = 1'b1; run = 1'b1;
    wait_start("t6", 50);
    run = 1'b0; test_en = 1'b0;
    wait_idle("t6", 1000);
    check("t6_l1_w0", 32'(wbuf[1][1]), 32'h0010);
    check("t6_l1_w1", 32'(wbuf[1][2]), 32'h0110);
    check("t6_l1_w2", 32'(wbuf[1][3]), 32'h0210);
    check("t6_rd_cnt", rd_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
